// File: rtl/vga_scan_controller.sv
// Raster-timing master: pixel enable, scan counters, sync generation and
// colour capture for a VGA DAC, with syncs delayed to line up with the colour.
module vga_scan_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_LAT = 1
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] x_ptr,
  output logic [9:0] y_ptr,
  output logic       video_on,
  input  logic [7:0] RGB,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pix_tick;
  logic [9:0]       r_x_ptr;
  logic [9:0]       r_y_ptr;
  logic             r_frame_start;
  logic [2:0]       r_stage [PIPE_LAT];
  logic             r_hsync;
  logic             r_vsync;
  logic [7:0]       r_vga;

  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_x_last;
  logic       w_y_last;
  logic       w_hs_act;
  logic       w_vs_act;
  logic       w_video_on;
  logic [2:0] w_tail;

  // The tick is registered one count early so it lines up with div_cnt==CLK_DIV-1.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_pix_tick <= 1'b0;
    end else begin
      r_div_cnt  <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
      r_pix_tick <= (r_div_cnt == DIV_PRE);
    end
  end

  assign w_x_last = (r_x_ptr == X_LAST);
  assign w_y_last = (r_y_ptr == Y_LAST);

  always_comb begin
    w_x_next = r_x_ptr;
    w_y_next = r_y_ptr;
    if (r_pix_tick) begin
      if (w_x_last) begin
        w_x_next = '0;
        w_y_next = w_y_last ? '0 : r_y_ptr + 1'b1;
      end else begin
        w_x_next = r_x_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_x_ptr       <= '0;
      r_y_ptr       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_x_ptr       <= w_x_next;
      r_y_ptr       <= w_y_next;
      r_frame_start <= r_pix_tick && w_x_last && w_y_last;
    end
  end

  // Stages carry active-high sync flags so a cleared stage means "no sync".
  assign w_hs_act   = (r_x_ptr >= HS_START) && (r_x_ptr < HS_END);
  assign w_vs_act   = (r_y_ptr >= VS_START) && (r_y_ptr < VS_END);
  assign w_video_on = (r_x_ptr < X_ACTIVE) && (r_y_ptr < Y_ACTIVE);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_stage[i] <= '0;
      end
    end else if (r_pix_tick) begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        r_stage[i] <= r_stage[i-1];
      end
      r_stage[0] <= {w_hs_act, w_vs_act, w_video_on};
    end
  end

  assign w_tail = r_stage[PIPE_LAT-1];

  // The colour for a position reaches RGB PIPE_LAT ticks after the counters
  // and is captured one tick later, so syncs take the same final register.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_vga   <= '0;
    end else if (r_pix_tick) begin
      r_hsync <= ~w_tail[2];
      r_vsync <= ~w_tail[1];
      r_vga   <= w_tail[0] ? RGB : 8'h00;
    end
  end

  assign pix_tick    = r_pix_tick;
  assign x_ptr       = r_x_ptr;
  assign y_ptr       = r_y_ptr;
  assign video_on    = w_video_on;
  assign frame_start = r_frame_start;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign vga_r       = r_vga[7:5];
  assign vga_g       = r_vga[4:2];
  assign vga_b       = r_vga[1:0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Randomised bench for vga_scan_controller: two configurations on a reduced
// raster, checked every clock against a tick-count based reference model.
module tb_vga_scan_controller;

  localparam int HA  = 300;
  localparam int HFP = 8;
  localparam int HSW = 16;
  localparam int HBP = 8;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit done_flag [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      if (n_bad >= 50) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int DIV = (gi == 0) ? 4 : 2;
      localparam int LAT = (gi == 0) ? 1 : 3;

      logic       rst = 1'b1;
      logic       tick;
      logic [9:0] xp, yp;
      logic       vid;
      logic [7:0] rgb = 8'h00;
      logic [2:0] vr, vg;
      logic [1:0] vb;
      logic       hs, vs, fs;

      vga_scan_controller #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(DIV), .PIPE_LAT(LAT)
      ) dut (
        .clk_100MHz(clk), .reset(rst), .pix_tick(tick), .x_ptr(xp), .y_ptr(yp),
        .video_on(vid), .RGB(rgb), .vga_r(vr), .vga_g(vg), .vga_b(vb),
        .hsync(hs), .vsync(vs), .frame_start(fs)
      );

      int         c = 0;
      int         mode = 0;
      int         mx = 0;
      int         my = 0;
      logic [7:0] sel [LAT] = '{default: 8'h00};
      logic [7:0] cols [int];
      string      pfx = $sformatf("cfg%0d.", gi);

      // Model: c clocks since reset release; n = c/DIV ticks; outputs show
      // the pixel LAT+1 ticks behind the counters.
      always @(posedge clk) begin : model
        int idx, px, py, p, n;
        logic [7:0] col;
        logic [31:0] e_hs, e_vs, e_col;
        #1;
        if (rst) begin
          c = 0;
          cols.delete();
        end else begin
          if (c % DIV == DIV - 1) begin
            idx = c / DIV;
            px  = idx % HT;
            case (mode)
              0:       col = 8'(px);
              1:       col = 8'hFF;
              default: col = 8'($urandom_range(0, 255));
            endcase
            cols[idx] = col;
            for (int i = LAT - 1; i > 0; i--) sel[i] = sel[i-1];
            sel[0] = col;
            rgb = sel[LAT-1];
          end
          c++;
        end
        n  = c / DIV;
        mx = n % HT;
        my = (n / HT) % VT;
        p  = n - LAT - 1;
        if (p < 0) begin
          e_hs = 1; e_vs = 1; e_col = 0;
        end else begin
          px    = p % HT;
          py    = (p / HT) % VT;
          e_hs  = (px >= HA + HFP && px < HA + HFP + HSW) ? 0 : 1;
          e_vs  = (py >= VA + VFP && py < VA + VFP + VSW) ? 0 : 1;
          e_col = (px < HA && py < VA) ? 32'(cols[p]) : 0;
        end
        check({pfx, "tick"}, 32'(tick), 32'(c % DIV == DIV - 1));
        check({pfx, "pos"}, {12'h0, xp, yp}, 32'(mx * 1024 + my));
        check({pfx, "video_on"}, 32'(vid), 32'(mx < HA && my < VA));
        check({pfx, "frame_start"}, 32'(fs), 32'(n > 0 && n % (HT * VT) == 0 && c % DIV == 0));
        check({pfx, "sync"}, {30'h0, hs, vs}, e_hs * 2 + e_vs);
        check({pfx, "colour"}, {24'h0, vr, vg, vb}, e_col);
      end

      initial begin : stim
        bit reached;
        rst  = 1'b1;
        mode = 0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (8000) @(negedge clk);
        mode = 1;
        repeat (12000) @(negedge clk);
        reached = 1'b0;
        for (int k = 0; k < 40000 && !reached; k++) begin
          @(negedge clk);
          reached = (mx == 300 && my == 3);
        end
        check({pfx, "reach_300_3"}, 32'(reached), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        for (int r = 0; r < 3; r++) begin
          mode = int'($urandom_range(0, 2));
          repeat ($urandom_range(200, 4000)) @(negedge clk);
          rst = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          rst = 1'b0;
        end
        mode = 2;
        repeat (6000) @(negedge clk);
        done_flag[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int k = 0; k < 90000 && !all_done; k++) begin
      @(posedge clk);
      all_done = done_flag[0] && done_flag[1];
    end
    check("finish", 32'(all_done), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
